rs_issue_select: RTL and testbench
==================================

RS_ISSUE_SELECT -- requirements
Module: rs_issue_select

Interface
REQ-001 SHALL have parameter RSLEN, default `RSLEN (8): number of RS lines observed.
REQ-002 SHALL have parameter IW, default 3: issue slots, matching the 3 CDB lanes.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port squash  input  1  branch-mispredict flush, synchronous.
REQ-006 SHALL have port rs_lines  input  RS_LINE[RSLEN]  current registered contents of each RS line.
REQ-007 SHALL have port not_ready  input  [RSLEN]  per-line operand-not-ready flag from each RS line.
REQ-008 SHALL have port ex_ready  input  [IW]  per-slot execute-stage accept; slot s is consumed on a cycle with is_valid[s] && ex_ready[s].
REQ-009 SHALL have port clear_vec  output  [RSLEN]  combinational; drives each RS line's clear input for lines granted this cycle.
REQ-010 SHALL have port is_line  output  RS_LINE[IW]  registered issue packets.
REQ-011 SHALL have port is_valid  output  [IW]  registered; slot holds a live packet.
REQ-012 SHALL have port issue_cnt  output  16  registered saturating count of granted instructions.

Function
REQ-013 Line i SHALL be eligible iff rs_lines[i].busy && !not_ready[i] && !squash.
REQ-014 Slot s SHALL be free in a cycle iff !is_valid[s] || ex_ready[s].
REQ-015 Let F = number of free slots (0..IW). Selector SHALL grant min(F, eligible count) lines.
REQ-016 Eligible lines SHALL be scanned from rr_ptr upward, wrapping RSLEN-1 -> 0.
REQ-017 Granted lines SHALL be placed into free slots in ascending slot index, in scan order.
REQ-018 clear_vec[i] SHALL be 1 in the same cycle that line i is granted, else 0; the line is empty next cycle and is never granted twice.
REQ-019 On the clock edge, a granted slot SHALL load is_line[s] <= rs_lines[i] and is_valid[s] <= 1.
REQ-020 A free slot with no grant SHALL load is_valid[s] <= 0.
REQ-021 A non-free slot (valid, !ex_ready) SHALL hold is_line/is_valid unchanged (stall), and SHALL receive no grant.
REQ-022 rr_ptr (clog2(RSLEN) bits) SHALL advance to (last granted index + 1) mod RSLEN when at least one grant occurs, and SHALL hold otherwise.
REQ-023 Issue latency SHALL be exactly 1 cycle: a line eligible in cycle n with a free slot SHALL appear on is_valid in cycle n+1.
REQ-024 issue_cnt SHALL add the number of grants each cycle and saturate at 16'hFFFF.
REQ-025 squash SHALL force clear_vec = 0 and no grants in that cycle; on the edge: is_valid <= 0 for all slots (including stalled ones), rr_ptr <= 0. issue_cnt holds.
REQ-026 All eligible lines with F = 0 SHALL produce clear_vec = 0; RS contents are untouched.
REQ-027 When rr_ptr = RSLEN-1 and lines RSLEN-1 and 0 are eligible, grant order SHALL be RSLEN-1 first, then 0.

Reset
REQ-028 While reset = 0, asynchronously: is_valid = 0, is_line = NOP packet (all fields zero, inst = `NOP, dest_reg_idx = `ZERO_REG), rr_ptr = 0, issue_cnt = 0.
REQ-029 clear_vec SHALL be 0 while reset = 0.
REQ-030 Reset asserted mid-stall SHALL discard held packets; first grant after release SHALL scan from line 0.

Verification
REQ-031 Reset release, lines 1, 4, 6 eligible, ex_ready = 3'b111 -> cycle 0: clear_vec = 8'b0101_0010; cycle 1: is_valid = 3'b111 with RSIDs 1, 4, 6; rr_ptr = 7.
REQ-032 rr_ptr = 7, lines 0, 2, 7 eligible -> slots 0, 1, 2 get RSIDs 7, 0, 2; rr_ptr = 3.
REQ-033 All 3 slots valid, ex_ready = 3'b010, lines 3 and 5 eligible (rr_ptr = 0) -> only line 3 granted, into slot 1; slots 0 and 2 unchanged; clear_vec = 8'b0000_1000.
REQ-034 ex_ready = 0 with all slots valid for 5 cycles, 8 lines eligible -> clear_vec = 0 all cycles, is_line stable, issue_cnt unchanged.
REQ-035 squash with 2 slots stalled and 4 lines eligible -> clear_vec = 0 that cycle; next cycle is_valid = 0, rr_ptr = 0.
REQ-036 issue_cnt preset to 16'hFFFE via 3-grant cycle path -> reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/rs_issue_select.sv
// Reservation-station issue selector: round-robin scan of eligible RS lines into
// up to IW free issue slots, with registered issue packets and a saturating grant count.
`ifndef RSLEN
`define RSLEN 8
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package rs_issue_pkg;
  typedef struct packed {
    logic        busy;
    logic [7:0]  rsid;
    logic [4:0]  dest_reg_idx;
    logic [31:0] inst;
    logic [31:0] pc;
  } RS_LINE;

  localparam RS_LINE NOP_PKT = '{busy: 1'b0, rsid: 8'h00, dest_reg_idx: `ZERO_REG,
                                 inst: `NOP, pc: 32'h0000_0000};
endpackage

module rs_issue_select
  import rs_issue_pkg::*;
#(
  parameter int unsigned RSLEN = `RSLEN,
  parameter int unsigned IW    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  RS_LINE [RSLEN-1:0]     rs_lines,
  input  logic   [RSLEN-1:0]     not_ready,
  input  logic   [IW-1:0]        ex_ready,
  output logic   [RSLEN-1:0]     clear_vec,
  output RS_LINE [IW-1:0]        is_line,
  output logic   [IW-1:0]        is_valid,
  output logic   [15:0]          issue_cnt
);

  localparam int unsigned PW = (RSLEN > 1) ? $clog2(RSLEN) : 1;
  localparam int unsigned CW = $clog2(IW + 1);
  localparam logic [PW:0]   RSLEN_W = (PW + 1)'(RSLEN);
  localparam logic [PW-1:0] LAST_IDX = PW'(RSLEN - 1);

  logic   [PW-1:0]          rr_ptr_q, rr_ptr_d;
  RS_LINE [IW-1:0]          is_line_q, is_line_d;
  logic   [IW-1:0]          is_valid_q, is_valid_d;
  logic   [15:0]            issue_cnt_q, issue_cnt_d;

  logic   [RSLEN-1:0]       elig;
  logic   [IW-1:0]          slot_free;
  logic   [IW-1:0]          slot_gnt;
  logic   [IW-1:0][PW-1:0]  gnt_idx;
  logic   [CW-1:0]          n_gnt;
  logic   [RSLEN-1:0]       clear_d;
  logic   [IW-1:0]          avail;
  logic                     placed;
  logic   [PW:0]            scan_sum;
  logic   [PW-1:0]          idx;
  logic   [16:0]            cnt_sum;

  // Gating with reset keeps clear_vec low while the block is held in reset.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < RSLEN; i++) begin
      elig[i] = rs_lines[i].busy && !not_ready[i] && !squash && reset;
    end
  end

  assign slot_free = ~is_valid_q | ex_ready;

  always_comb begin
    clear_d  = '0;
    slot_gnt = '0;
    gnt_idx  = '0;
    n_gnt    = '0;
    rr_ptr_d = rr_ptr_q;
    avail    = slot_free;
    scan_sum = '0;
    idx      = '0;
    placed   = 1'b0;
    for (int unsigned k = 0; k < RSLEN; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PW + 1)'(k);
      if (scan_sum >= RSLEN_W) scan_sum = scan_sum - RSLEN_W;
      idx    = scan_sum[PW-1:0];
      placed = 1'b0;
      if (elig[idx]) begin
        for (int unsigned s = 0; s < IW; s++) begin
          if (!placed && avail[s]) begin
            avail[s]     = 1'b0;
            slot_gnt[s]  = 1'b1;
            gnt_idx[s]   = idx;
            clear_d[idx] = 1'b1;
            rr_ptr_d     = (idx == LAST_IDX) ? '0 : idx + PW'(1);
            n_gnt        = n_gnt + CW'(1);
            placed       = 1'b1;
          end
        end
      end
    end
    if (squash) rr_ptr_d = '0;
  end

  always_comb begin
    is_line_d  = is_line_q;
    is_valid_d = is_valid_q;
    for (int unsigned s = 0; s < IW; s++) begin
      if (slot_free[s]) begin
        is_valid_d[s] = slot_gnt[s];
        if (slot_gnt[s]) is_line_d[s] = rs_lines[gnt_idx[s]];
      end
    end
    if (squash) is_valid_d = '0;
    cnt_sum     = {1'b0, issue_cnt_q} + 17'(n_gnt);
    issue_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      is_valid_q  <= '0;
      issue_cnt_q <= '0;
      for (int unsigned s = 0; s < IW; s++) is_line_q[s] <= NOP_PKT;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      is_valid_q  <= is_valid_d;
      issue_cnt_q <= issue_cnt_d;
      is_line_q   <= is_line_d;
    end
  end

  assign clear_vec = clear_d;
  assign is_line   = is_line_q;
  assign is_valid  = is_valid_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: the bench plays the RS, driving line contents
// per step and comparing against hand-derived grant/slot/count values.
module tb_rs_issue_select;
  import rs_issue_pkg::*;

  localparam int unsigned RSLEN = 8;
  localparam int unsigned IW    = 3;

  logic                 clock;
  logic                 reset;
  logic                 squash;
  RS_LINE [RSLEN-1:0]   rs_lines;
  logic   [RSLEN-1:0]   not_ready;
  logic   [IW-1:0]      ex_ready;
  logic   [RSLEN-1:0]   clear_vec;
  RS_LINE [IW-1:0]      is_line;
  logic   [IW-1:0]      is_valid;
  logic   [15:0]        issue_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rs_issue_select #(.RSLEN(RSLEN), .IW(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .rs_lines  (rs_lines),
    .not_ready (not_ready),
    .ex_ready  (ex_ready),
    .clear_vec (clear_vec),
    .is_line   (is_line),
    .is_valid  (is_valid),
    .issue_cnt (issue_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic RS_LINE mk(input int unsigned i, input logic b);
    RS_LINE l;
    l.busy         = b;
    l.rsid         = 8'(i);
    l.dest_reg_idx = 5'(i + 1);
    l.inst         = 32'h1000_0000 | i;
    l.pc           = 32'h0000_0400 + 32'(4 * i);
    return l;
  endfunction

  task automatic set_busy(input logic [RSLEN-1:0] mask);
    for (int i = 0; i < RSLEN; i++) rs_lines[i] = mk(i, mask[i]);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_slots(input string tag, input logic [IW-1:0] v,
                             input int unsigned r0, input int unsigned r1, input int unsigned r2);
    check({tag, " valid"}, 128'(is_valid), 128'(v));
    if (v[0]) check({tag, " slot0"}, 128'(is_line[0]), 128'(mk(r0, 1'b1)));
    if (v[1]) check({tag, " slot1"}, 128'(is_line[1]), 128'(mk(r1, 1'b1)));
    if (v[2]) check({tag, " slot2"}, 128'(is_line[2]), 128'(mk(r2, 1'b1)));
  endtask

  initial begin
    reset     = 1'b1;
    squash    = 1'b0;
    ex_ready  = '0;
    not_ready = '0;
    set_busy(8'b0101_0010);
    #1 reset = 1'b0;
    tick();
    tick();
    check("rst valid", 128'(is_valid), 128'(3'b000));
    check("rst slot0 nop", 128'(is_line[0]), 128'(NOP_PKT));
    check("rst slot2 nop", 128'(is_line[2]), 128'(NOP_PKT));
    check("rst cnt", 128'(issue_cnt), 128'(16'h0000));
    check("rst clear", 128'(clear_vec), 128'(8'h00));

    // Lines 1,4,6 from pointer 0.
    reset    = 1'b1;
    ex_ready = 3'b111;
    #1;
    check("first clear", 128'(clear_vec), 128'(8'b0101_0010));
    tick();
    set_busy(8'b0000_0000);
    check_slots("first", 3'b111, 1, 4, 6);
    check("first cnt", 128'(issue_cnt), 128'(16'd3));

    // Pointer 7: lines 0,2,7; line 3 busy but not ready.
    set_busy(8'b1000_1101);
    not_ready = 8'b0000_1000;
    #1;
    check("wrap clear", 128'(clear_vec), 128'(8'b1000_0101));
    tick();
    set_busy(8'b0000_0000);
    not_ready = '0;
    check_slots("wrap", 3'b111, 7, 0, 2);
    check("wrap cnt", 128'(issue_cnt), 128'(16'd6));

    // Pointer 3: lines 5,6,7 fill all slots and move pointer to 0.
    set_busy(8'b1110_0000);
    #1;
    check("fill clear", 128'(clear_vec), 128'(8'b1110_0000));
    tick();
    set_busy(8'b0000_0000);
    check_slots("fill", 3'b111, 5, 6, 7);

    // Only slot 1 free; lines 3 and 5 eligible from pointer 0.
    ex_ready = 3'b010;
    set_busy(8'b0010_1000);
    #1;
    check("partial clear", 128'(clear_vec), 128'(8'b0000_1000));
    tick();
    set_busy(8'b0010_0000);
    check_slots("partial", 3'b111, 5, 3, 7);
    check("partial cnt", 128'(issue_cnt), 128'(16'd10));

    // Full stall with every line eligible.
    ex_ready = 3'b000;
    set_busy(8'b1111_1111);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall clear", 128'(clear_vec), 128'(8'h00));
      tick();
      check_slots("stall", 3'b111, 5, 3, 7);
      check("stall cnt", 128'(issue_cnt), 128'(16'd10));
    end

    // Squash with slots 0,1 stalled; lines 1,2,3,7 eligible.
    ex_ready = 3'b100;
    set_busy(8'b1000_1110);
    squash   = 1'b1;
    #1;
    check("squash clear", 128'(clear_vec), 128'(8'h00));
    tick();
    squash = 1'b0;
    check("squash valid", 128'(is_valid), 128'(3'b000));
    check("squash cnt", 128'(issue_cnt), 128'(16'd10));

    // Pointer back at 0 selects 1,2,3 rather than 7,1,2.
    ex_ready = 3'b111;
    #1;
    check("post squash clear", 128'(clear_vec), 128'(8'b0000_1110));
    tick();
    set_busy(8'b0000_0000);
    check_slots("post squash", 3'b111, 1, 2, 3);
    check("post squash cnt", 128'(issue_cnt), 128'(16'd13));

    // Move pointer to 7, then lines 7 and 0 must issue 7 first.
    set_busy(8'b0111_0000);
    tick();
    set_busy(8'b1000_0001);
    #1;
    check("edge clear", 128'(clear_vec), 128'(8'b1000_0001));
    tick();
    set_busy(8'b0000_0000);
    check_slots("edge", 3'b011, 7, 0, 0);
    check("edge cnt", 128'(issue_cnt), 128'(16'd18));

    // Reset during a stall discards packets; next scan starts at line 0.
    ex_ready = 3'b000;
    tick();
    check_slots("hold", 3'b011, 7, 0, 0);
    set_busy(8'b0010_0001);
    reset = 1'b0;
    #1;
    check("midrst valid", 128'(is_valid), 128'(3'b000));
    check("midrst cnt", 128'(issue_cnt), 128'(16'd0));
    check("midrst slot0 nop", 128'(is_line[0]), 128'(NOP_PKT));
    check("midrst clear", 128'(clear_vec), 128'(8'h00));
    tick();
    reset    = 1'b1;
    ex_ready = 3'b111;
    #1;
    check("after rst clear", 128'(clear_vec), 128'(8'b0010_0001));
    tick();
    check_slots("after rst", 3'b011, 0, 5, 0);
    check("after rst cnt", 128'(issue_cnt), 128'(16'd2));

    // Saturation: 2 + 21844*3 = 16'hFFFE, then one more 3-grant cycle clamps.
    set_busy(8'b1111_1111);
    for (int n = 0; n < 21844; n++) tick();
    check("sat pre", 128'(issue_cnt), 128'(16'hFFFE));
    tick();
    check("sat clamp", 128'(issue_cnt), 128'(16'hFFFF));
    tick();
    tick();
    check("sat hold", 128'(issue_cnt), 128'(16'hFFFF));
    check("sat valid", 128'(is_valid), 128'(3'b111));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
